// File: rtl/reaction_game_if.sv
// Bundle of button inputs, random source and display outputs for the
// reaction game core. The core uses the slave modport; whoever drives the
// buttons and reads the display uses the master modport.
interface reaction_game_if #(
  parameter int NUM_W  = 14,
  parameter int LED_W  = 16,
  parameter int MODE_W = 2,
  parameter int RND_W  = 2
);
  logic              btnU;
  logic              btnD;
  logic              btnS;
  logic [NUM_W-1:0]  rand_num;
  logic [2:0]        select;
  logic [MODE_W-1:0] mode;
  logic [NUM_W-1:0]  number;
  logic [LED_W-1:0]  led;
  logic [RND_W-1:0]  round;
  logic [NUM_W-1:0]  best;

  modport master (
    output btnU, btnD, btnS, rand_num,
    input  select, mode, number, led, round, best
  );

  modport slave (
    input  btnU, btnD, btnS, rand_num,
    output select, mode, number, led, round, best
  );
endinterface

// File: rtl/reaction_game_core.sv
// Multi-round reaction game: choose a mode, show a random target, count up,
// and stop as close to the target as possible. Each round's error drives the
// LED bar, a running total and the best (smallest) error of the game.
module reaction_game_core #(
  parameter int NUM_MODES  = 3,
  parameter int START_MODE = 1,
  parameter int BASE_TICKS = 100000,
  parameter int NUM_W      = 14,
  parameter int LED_W      = 16,
  parameter int LED_STEP   = 30,
  parameter int ROUNDS     = 4
) (
  input logic            clk,
  input logic            rst,
  reaction_game_if.slave bus
);

  localparam int MODE_W = $clog2(NUM_MODES);
  localparam int RND_W  = (ROUNDS > 1) ? $clog2(ROUNDS) : 1;
  localparam int TOT_W  = NUM_W + $clog2(ROUNDS + 1);
  localparam int TICK_W = $clog2(BASE_TICKS * NUM_MODES + 1);

  localparam logic [MODE_W-1:0] MODE_MAX   = MODE_W'(NUM_MODES - 1);
  localparam logic [RND_W-1:0]  LAST_ROUND = RND_W'(ROUNDS - 1);
  localparam logic [NUM_W-1:0]  NUM_MAX    = {NUM_W{1'b1}};

  typedef enum logic [2:0] {
    IDLE   = 3'd0,
    RUN    = 3'd1,
    RESULT = 3'd2,
    SHOW   = 3'd3,
    DONE   = 3'd4
  } state_t;

  state_t state;
  state_t state_next;

  logic [2:0]        btn_now;
  logic [2:0]        btn_q;
  logic [2:0]        btn_held;
  logic [2:0]        press;
  logic              up_press;
  logic              down_press;
  logic              go_press;

  logic [MODE_W-1:0] mode_r;
  logic [NUM_W-1:0]  number_r;
  logic [NUM_W-1:0]  target_r;
  logic [NUM_W-1:0]  best_r;
  logic [NUM_W-1:0]  err;
  logic [LED_W-1:0]  led_r;
  logic [RND_W-1:0]  round_r;
  logic [TOT_W-1:0]  total_r;
  logic [TICK_W-1:0] tick_r;
  logic [TICK_W-1:0] period_last;

  // A button that was already high at reset stays blocked until it is seen
  // low, so holding it through reset never counts as a press on release.
  assign btn_now    = {bus.btnU, bus.btnD, bus.btnS};
  assign press      = btn_now & ~btn_q & ~btn_held;
  assign up_press   = press[2];
  assign down_press = press[1];
  assign go_press   = press[0];

  // Accuracy bar: one LED goes dark (from the LSB) per LED_STEP of error.
  function automatic logic [LED_W-1:0] bar(input logic [NUM_W-1:0] e);
    int k;
    k = int'(e) / LED_STEP;
    if (k >= LED_W) return '0;
    return {LED_W{1'b1}} << k;
  endfunction

  // Button history used for edge detection and the post-reset block.
  always_ff @(posedge clk) begin
    if (rst) begin
      btn_q    <= '0;
      btn_held <= btn_now;
    end else begin
      btn_q    <= btn_now;
      btn_held <= btn_held & btn_now;
    end
  end

  // Last tick of the current mode's counter period, and the round's error.
  always_comb begin
    period_last = TICK_W'(BASE_TICKS * (NUM_MODES - int'(mode_r)) - 1);
    if (number_r >= target_r) err = number_r - target_r;
    else                      err = target_r - number_r;
  end

  // State register.
  always_ff @(posedge clk) begin
    if (rst) state <= IDLE;
    else     state <= state_next;
  end

  // Next-state logic: every transition is triggered by a start/stop press.
  always_comb begin
    state_next = state;
    if (go_press) begin
      case (state)
        IDLE:    state_next = SHOW;
        SHOW:    state_next = RUN;
        RUN:     state_next = RESULT;
        RESULT:  state_next = (round_r == LAST_ROUND) ? DONE : SHOW;
        DONE:    state_next = IDLE;
        default: state_next = IDLE;
      endcase
    end
  end

  // State code seen by the display driver.
  always_comb begin
    bus.select = state;
  end

  // Game datapath: mode, counter, scoring and display registers.
  always_ff @(posedge clk) begin
    if (rst) begin
      mode_r   <= MODE_W'(START_MODE);
      number_r <= '0;
      target_r <= '0;
      best_r   <= NUM_MAX;
      led_r    <= '0;
      round_r  <= '0;
      total_r  <= '0;
      tick_r   <= '0;
    end else begin
      case (state)
        IDLE: begin
          if (up_press && !down_press && mode_r != MODE_MAX)
            mode_r <= mode_r + MODE_W'(1);
          else if (down_press && !up_press && mode_r != '0)
            mode_r <= mode_r - MODE_W'(1);
          if (go_press) begin
            target_r <= bus.rand_num;
            number_r <= bus.rand_num;
            round_r  <= '0;
            total_r  <= '0;
            best_r   <= NUM_MAX;
            led_r    <= '0;
          end
        end
        SHOW: begin
          if (go_press) begin
            number_r <= '0;
            tick_r   <= '0;
          end
        end
        RUN: begin
          if (go_press) begin
            number_r <= err;
            total_r  <= total_r + TOT_W'(err);
            best_r   <= (err < best_r) ? err : best_r;
            led_r    <= bar(err);
          end else if (tick_r == period_last) begin
            tick_r <= '0;
            if (number_r != NUM_MAX) number_r <= number_r + NUM_W'(1);
          end else begin
            tick_r <= tick_r + TICK_W'(1);
          end
        end
        RESULT: begin
          if (go_press) begin
            if (round_r == LAST_ROUND) begin
              number_r <= (total_r > TOT_W'(NUM_MAX)) ? NUM_MAX : total_r[NUM_W-1:0];
              led_r    <= bar(best_r);
            end else begin
              round_r  <= round_r + RND_W'(1);
              target_r <= bus.rand_num;
              number_r <= bus.rand_num;
              led_r    <= '0;
            end
          end
        end
        DONE: begin
          if (go_press) begin
            number_r <= '0;
            led_r    <= '0;
            round_r  <= '0;
          end
        end
        default: ;
      endcase
    end
  end

  assign bus.mode   = mode_r;
  assign bus.number = number_r;
  assign bus.led    = led_r;
  assign bus.round  = round_r;
  assign bus.best   = best_r;

endmodule

// File: tb/tb_reaction_game_core.sv
// Self-checking bench for reaction_game_core: directed game scenarios with
// literal expectations, randomized play, and a small narrow-width instance
// for counter saturation. A behavioural game model is compared every cycle.
module tb_reaction_game_core;

  localparam int NUM_MODES  = 3;
  localparam int START_MODE = 1;
  localparam int BASE_TICKS = 4;
  localparam int NUM_W      = 14;
  localparam int LED_W      = 16;
  localparam int LED_STEP   = 30;
  localparam int ROUNDS     = 2;
  localparam int MODE_W     = 2;
  localparam int RND_W      = 1;
  localparam int MAXN       = (1 << NUM_W) - 1;

  logic clk = 1'b0;
  logic rst = 1'b1;
  int   checks = 0;
  int   errors = 0;

  always #5 clk = ~clk;

  reaction_game_if #(.NUM_W(NUM_W), .LED_W(LED_W), .MODE_W(MODE_W), .RND_W(RND_W)) bus ();
  reaction_game_if #(.NUM_W(4), .LED_W(16), .MODE_W(2), .RND_W(1)) sbus ();

  reaction_game_core #(
    .NUM_MODES(NUM_MODES), .START_MODE(START_MODE), .BASE_TICKS(BASE_TICKS),
    .NUM_W(NUM_W), .LED_W(LED_W), .LED_STEP(LED_STEP), .ROUNDS(ROUNDS)
  ) dut (
    .clk(clk),
    .rst(rst),
    .bus(bus)
  );

  reaction_game_core #(
    .NUM_MODES(3), .START_MODE(1), .BASE_TICKS(1),
    .NUM_W(4), .LED_W(16), .LED_STEP(30), .ROUNDS(2)
  ) dut_sat (
    .clk(clk),
    .rst(rst),
    .bus(sbus)
  );

  // Behavioural model state: the game as the player sees it.
  int m_state, m_mode, m_number, m_target, m_round, m_total, m_best, m_led;
  int run_cyc;
  bit prev_u, prev_d, prev_s;
  bit arm_u, arm_d, arm_s;

  function automatic int barOf(input int e);
    int k;
    k = e / LED_STEP;
    if (k >= LED_W) return 0;
    return (2 ** LED_W) - (2 ** k);
  endfunction

  task automatic stepModel();
    bit pu, pd, ps;
    int err;
    if (rst) begin
      m_state = 0; m_mode = START_MODE; m_number = 0; m_target = 0;
      m_round = 0; m_total = 0; m_best = MAXN; m_led = 0; run_cyc = 0;
      prev_u = 0; prev_d = 0; prev_s = 0;
      arm_u = !bus.btnU; arm_d = !bus.btnD; arm_s = !bus.btnS;
      return;
    end
    pu = bus.btnU && !prev_u && arm_u;
    pd = bus.btnD && !prev_d && arm_d;
    ps = bus.btnS && !prev_s && arm_s;
    prev_u = bus.btnU; prev_d = bus.btnD; prev_s = bus.btnS;
    if (!bus.btnU) arm_u = 1;
    if (!bus.btnD) arm_d = 1;
    if (!bus.btnS) arm_s = 1;
    case (m_state)
      0: begin
        if (pu && !pd && m_mode < NUM_MODES - 1) m_mode++;
        else if (pd && !pu && m_mode > 0) m_mode--;
        if (ps) begin
          m_state = 3; m_target = int'(bus.rand_num); m_number = m_target;
          m_round = 0; m_total = 0; m_best = MAXN; m_led = 0;
        end
      end
      3: if (ps) begin m_state = 1; m_number = 0; run_cyc = 0; end
      1: begin
        if (ps) begin
          err = (m_number > m_target) ? m_number - m_target : m_target - m_number;
          m_state = 2; m_number = err; m_total += err;
          if (err < m_best) m_best = err;
          m_led = barOf(err);
        end else begin
          run_cyc++;
          m_number = run_cyc / (BASE_TICKS * (NUM_MODES - m_mode));
          if (m_number > MAXN) m_number = MAXN;
        end
      end
      2: if (ps) begin
        if (m_round == ROUNDS - 1) begin
          m_state = 4; m_number = (m_total > MAXN) ? MAXN : m_total;
          m_led = barOf(m_best);
        end else begin
          m_state = 3; m_round++; m_target = int'(bus.rand_num);
          m_number = m_target; m_led = 0;
        end
      end
      4: if (ps) begin m_state = 0; m_number = 0; m_led = 0; m_round = 0; end
      default: ;
    endcase
  endtask

  // Compare process: advance the model on each edge, check just after it.
  initial begin
    forever begin
      @(posedge clk);
      stepModel();
      #1;
      checks++;
      if (int'(bus.select) != m_state || int'(bus.mode) != m_mode ||
          int'(bus.number) != m_number || int'(bus.led) != m_led ||
          int'(bus.round) != m_round || int'(bus.best) != m_best) begin
        errors++;
        $display("[TB] FAIL model_cmp t=%0t sel %0d/%0d mode %0d/%0d num %0d/%0d led %h/%h rnd %0d/%0d best %0d/%0d (actual/required)",
                 $time, bus.select, m_state, bus.mode, m_mode, bus.number, m_number,
                 bus.led, m_led[LED_W-1:0], bus.round, m_round, bus.best, m_best);
      end
    end
  end

  task automatic checkOutput(input string name, input int actual, input int expected);
    checks++;
    if (actual != expected) begin
      errors++;
      $display("[TB] FAIL %s actual=%0d required=%0d", name, actual, expected);
    end
  endtask

  task automatic applyStimulus(input bit u, input bit d, input bit s, input int rnd);
    @(negedge clk);
    bus.btnU = u;
    bus.btnD = d;
    bus.btnS = s;
    bus.rand_num = NUM_W'(rnd);
  endtask

  task automatic pressS(input int rnd);
    applyStimulus(0, 0, 1, rnd);
    applyStimulus(0, 0, 0, rnd);
  endtask

  // Leaves n counting cycles elapsed in RUN before the next press is sampled.
  task automatic runFor(input int n);
    repeat (n - 1) applyStimulus(0, 0, 0, 0);
  endtask

  initial begin
    bus.btnU = 0; bus.btnD = 0; bus.btnS = 0; bus.rand_num = '0;
    sbus.btnU = 0; sbus.btnD = 0; sbus.btnS = 0; sbus.rand_num = '0;
    repeat (3) @(negedge clk);
    checkOutput("reset_select", int'(bus.select), 0);
    checkOutput("reset_mode", int'(bus.mode), 1);
    checkOutput("reset_best", int'(bus.best), 16383);
    rst = 1'b0;

    repeat (3) begin applyStimulus(1, 0, 0, 0); applyStimulus(0, 0, 0, 0); end
    checkOutput("mode_up_sat", int'(bus.mode), 2);
    repeat (3) begin applyStimulus(0, 1, 0, 0); applyStimulus(0, 0, 0, 0); end
    checkOutput("mode_down_sat", int'(bus.mode), 0);
    applyStimulus(1, 1, 0, 0); applyStimulus(0, 0, 0, 0);
    checkOutput("mode_both", int'(bus.mode), 0);
    repeat (2) begin applyStimulus(1, 0, 0, 0); applyStimulus(0, 0, 0, 0); end

    // Game 1: exact hit, then a miss of 98.
    pressS(5);
    checkOutput("show_number", int'(bus.number), 5);
    checkOutput("show_select", int'(bus.select), 3);
    pressS(5);
    runFor(22);
    pressS(0);
    checkOutput("hit_err", int'(bus.number), 0);
    checkOutput("hit_led", int'(bus.led), 16'hFFFF);
    checkOutput("hit_select", int'(bus.select), 2);
    pressS(100);
    checkOutput("round1", int'(bus.round), 1);
    pressS(0);
    runFor(10);
    pressS(0);
    checkOutput("miss_err", int'(bus.number), 98);
    checkOutput("miss_led", int'(bus.led), 16'hFFF8);
    pressS(0);
    checkOutput("g1_total", int'(bus.number), 98);
    pressS(0);

    // Game 2: target 0, counter at 600 darkens the whole bar.
    pressS(0); pressS(0);
    runFor(2400);
    pressS(0);
    checkOutput("far_err", int'(bus.number), 600);
    checkOutput("far_led", int'(bus.led), 0);
    pressS(50); pressS(0);
    runFor(4);
    pressS(0);
    pressS(0);
    checkOutput("g2_total", int'(bus.number), 649);
    pressS(0);

    // Game 3: errors 40 and 10.
    pressS(100); pressS(0);
    runFor(240);
    pressS(0);
    checkOutput("err40", int'(bus.number), 40);
    pressS(10); pressS(0);
    runFor(1);
    pressS(0);
    checkOutput("err10", int'(bus.number), 10);
    pressS(0);
    checkOutput("done_total", int'(bus.number), 50);
    checkOutput("done_best", int'(bus.best), 10);
    checkOutput("done_led", int'(bus.led), 16'hFFFF);
    checkOutput("done_round", int'(bus.round), 1);
    checkOutput("done_select", int'(bus.select), 4);
    pressS(0);
    checkOutput("idle_round", int'(bus.round), 0);
    checkOutput("idle_best", int'(bus.best), 10);
    checkOutput("idle_select", int'(bus.select), 0);

    // Reset mid-RUN with btnS held high.
    pressS(7); pressS(7);
    repeat (5) applyStimulus(0, 0, 0, 7);
    @(negedge clk);
    rst = 1'b1; bus.btnS = 1'b1;
    @(negedge clk);
    rst = 1'b0;
    checkOutput("rst_select", int'(bus.select), 0);
    checkOutput("rst_number", int'(bus.number), 0);
    checkOutput("rst_mode", int'(bus.mode), START_MODE);
    repeat (4) applyStimulus(0, 0, 1, 7);
    checkOutput("held_no_start", int'(bus.select), 0);
    applyStimulus(0, 0, 0, 7);
    pressS(7);
    checkOutput("restart_select", int'(bus.select), 3);
    checkOutput("restart_number", int'(bus.number), 7);

    // Randomized play with occasional resets.
    for (int i = 0; i < 4000; i++) begin
      int r;
      r = ($urandom_range(0, 3) == 0) ? int'($urandom_range(0, MAXN)) : int'($urandom_range(0, 400));
      @(negedge clk);
      rst = ($urandom_range(0, 599) == 0);
      bus.btnU = ($urandom_range(0, 7) == 0);
      bus.btnD = ($urandom_range(0, 7) == 0);
      bus.btnS = ($urandom_range(0, 24) == 0);
      bus.rand_num = NUM_W'(r);
    end
    @(negedge clk);
    rst = 1'b0; bus.btnU = 0; bus.btnD = 0; bus.btnS = 0;
    repeat (2) @(negedge clk);

    // Narrow instance: 4-bit counter must saturate at 15.
    sbus.rand_num = 4'd3; sbus.btnS = 1'b1;
    @(negedge clk); sbus.btnS = 1'b0;
    @(negedge clk); sbus.btnS = 1'b1;
    @(negedge clk); sbus.btnS = 1'b0;
    repeat (40) @(negedge clk);
    checkOutput("sat_number", int'(sbus.number), 15);
    checkOutput("sat_select", int'(sbus.select), 1);
    sbus.btnS = 1'b1;
    @(negedge clk); sbus.btnS = 1'b0;
    checkOutput("sat_err", int'(sbus.number), 12);
    checkOutput("sat_led", int'(sbus.led), 16'hFFFF);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
